clock_period_meter: RTL and testbench

CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

---
 rtl/clock_meter_pkg.sv | 14 +
 rtl/clock_period_meter_if.sv | 27 ++
 rtl/sync_edge_detect.sv | 26 ++
 rtl/clock_period_meter.sv | 97 +++++++++
 tb/tb_clock_period_meter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_meter_pkg.sv
// Shared constants and FSM encoding for the clock period meter.
// Defaults size the counter for periods up to 2**26-1 reference cycles.
package clock_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } meter_state_e;

  localparam int unsigned CNT_W_DEF   = 26;
  localparam int unsigned TIMEOUT_DEF = (32'd1 << CNT_W_DEF) - 32'd1;

endpackage

// File: rtl/clock_period_meter_if.sv
// Control and result signals of the period meter; master drives enable/slow_in.
// No handshake: results are single-cycle pulses plus a held period value.
interface clock_period_meter_if
  import clock_meter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic             enable;
  logic             slow_in;
  logic             rise_tick;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             timeout;
  logic             busy;

  modport master (
    output enable, slow_in,
    input  rise_tick, period_out, period_valid, timeout, busy
  );

  modport slave (
    input  enable, slow_in,
    output rise_tick, period_out, period_valid, timeout, busy
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus history flop; rise is high for one cycle per rising edge of d.
// rise is combinational from the flops, valid two clock_in edges after d goes high.
module sync_edge_detect (
  input  logic clock_in,
  input  logic reset_n,
  input  logic d,
  output logic rise
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures rising-to-rising period of an asynchronous slow_in in clock_in cycles.
// Results register on the same edge as rise_tick (3 edges after slow_in goes high); no backpressure.
module clock_period_meter
  import clock_meter_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clock_in,
  input  logic                reset_n,
  clock_period_meter_if.slave mif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  meter_state_e     state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             rise;
  logic             rise_tick_q;
  logic             period_valid_q, period_valid_d;
  logic             timeout_q, timeout_d;
  logic             at_limit;

  sync_edge_detect u_sync (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .d        (mif.slow_in),
    .rise     (rise)
  );

  assign at_limit = (count_q == CNT_LAST);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!mif.enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_ARM;
        ST_ARM:     if (rise) state_d = ST_MEASURE;
        ST_MEASURE: if (!rise && at_limit) state_d = ST_ARM;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // A rise at the limit still counts as a period; timeout only fires without one.
  always_comb begin
    count_d        = '0;
    period_d       = period_q;
    period_valid_d = 1'b0;
    timeout_d      = 1'b0;
    if (mif.enable && state_q == ST_MEASURE) begin
      if (rise) begin
        period_d       = count_q + CNT_ONE;
        period_valid_d = 1'b1;
      end else if (at_limit) begin
        timeout_d = 1'b1;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      count_q        <= '0;
      period_q       <= '0;
      rise_tick_q    <= 1'b0;
      period_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      count_q        <= count_d;
      period_q       <= period_d;
      rise_tick_q    <= rise;
      period_valid_q <= period_valid_d;
      timeout_q      <= timeout_d;
    end
  end

  assign mif.rise_tick    = rise_tick_q;
  assign mif.period_out   = period_q;
  assign mif.period_valid = period_valid_q;
  assign mif.timeout      = timeout_q;
  assign mif.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: directed scenarios plus random square waves,
// every cycle compared against an edge-timestamp reference model.
module tb_clock_period_meter;

  localparam int unsigned CW  = 26;
  localparam int unsigned TMO = 64;
  localparam int unsigned VW  = CW + 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  clock_period_meter_if #(.CNT_W(CW)) mif ();

  clock_period_meter #(.CNT_W(CW), .TIMEOUT(TMO)) dut (
    .clock_in (clk),
    .reset_n  (rst_n),
    .mif      (mif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: slow_in samples of the last three edges, mode and last-rise timestamp.
  bit smp1, smp2, smp3;
  int mode;       // 0 idle, 1 waiting for first rise, 2 measuring
  int edge_n;
  int last_rise;
  int m_per;
  logic [VW-1:0] exp_v;
  logic [VW-1:0] obs_v;

  assign obs_v = {mif.rise_tick, mif.period_valid, mif.timeout, mif.busy, mif.period_out};

  task automatic model_reset();
    smp1  = 1'b0;
    smp2  = 1'b0;
    smp3  = 1'b0;
    mode  = 0;
    m_per = 0;
    exp_v = '0;
  endtask

  // Drive one cycle, then advance the model by the edge that sampled these inputs.
  task automatic cycle(input logic en, input logic sin);
    bit r, pv, to;
    mif.enable  = en;
    mif.slow_in = sin;
    @(posedge clk);
    #1;
    edge_n++;
    r = smp2 & ~smp3;
    smp3 = smp2;
    smp2 = smp1;
    smp1 = sin;
    pv = 1'b0;
    to = 1'b0;
    if (!en) begin
      mode = 0;
    end else if (mode == 0) begin
      mode = 1;
    end else if (mode == 1) begin
      if (r) begin
        mode = 2;
        last_rise = edge_n;
      end
    end else if (r) begin
      m_per = edge_n - last_rise;
      pv = 1'b1;
      last_rise = edge_n;
    end else if (edge_n - last_rise == int'(TMO)) begin
      to = 1'b1;
      mode = 1;
    end
    exp_v = {r, pv, to, (mode != 0), CW'(m_per)};
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs_v !== '0) begin
      n_bad++;
      $display("FAIL reset_async got=%h want=0", obs_v);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_v !== '0) begin
      n_bad++;
      $display("FAIL reset_held got=%h want=0", obs_v);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_square10();
    int pv_cnt = 0;
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 10; c++) begin
        cycle(1'b1, c < 5);
        n_cmp++;
        if (obs_v !== exp_v) begin
          n_bad++;
          $display("FAIL square10 edge=%0d got=%h want=%h", edge_n, obs_v, exp_v);
        end
        if (mif.period_valid === 1'b1) pv_cnt++;
      end
    end
    n_cmp++;
    if (pv_cnt != 5) begin
      n_bad++;
      $display("FAIL square10_valid_count got=%0d want=5", pv_cnt);
    end
    n_cmp++;
    if (mif.period_out !== 26'd10) begin
      n_bad++;
      $display("FAIL square10_period got=%0d want=10", mif.period_out);
    end
  endtask

  task automatic test_timeout();
    int to_cnt = 0;
    for (int c = 0; c < 105; c++) begin
      cycle(1'b1, c < 5);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL timeout edge=%0d got=%h want=%h", edge_n, obs_v, exp_v);
      end
      if (mif.timeout === 1'b1) to_cnt++;
    end
    n_cmp++;
    if (to_cnt != 1) begin
      n_bad++;
      $display("FAIL timeout_count got=%0d want=1", to_cnt);
    end
    n_cmp++;
    if (mif.period_out !== 26'd10 || mif.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_hold period=%0d busy=%b want 10/1", mif.period_out, mif.busy);
    end
  endtask

  task automatic test_exact64();
    int pv_cnt = 0;
    int to_cnt = 0;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 64; c++) begin
        cycle(1'b1, c < 32);
        n_cmp++;
        if (obs_v !== exp_v) begin
          n_bad++;
          $display("FAIL exact64 edge=%0d got=%h want=%h", edge_n, obs_v, exp_v);
        end
        if (mif.period_valid === 1'b1) pv_cnt++;
        if (mif.timeout === 1'b1) to_cnt++;
      end
    end
    n_cmp++;
    if (pv_cnt != 3 || to_cnt != 0) begin
      n_bad++;
      $display("FAIL exact64_pulses valid=%0d timeout=%0d want 3/0", pv_cnt, to_cnt);
    end
    n_cmp++;
    if (mif.period_out !== 26'd64) begin
      n_bad++;
      $display("FAIL exact64_period got=%0d want=64", mif.period_out);
    end
  endtask

  task automatic test_enable_drop();
    int  rt_cnt = 0;
    bit  restored = 1'b0;
    bit  first_seen = 1'b0;
    logic en;
    for (int p = 0; p < 7; p++) begin
      for (int c = 0; c < 20; c++) begin
        en = !(p == 2 && c >= 4 && c < 14);
        if (p == 2 && c == 14) restored = 1'b1;
        cycle(en, c < 10);
        n_cmp++;
        if (obs_v !== exp_v) begin
          n_bad++;
          $display("FAIL enable_drop edge=%0d got=%h want=%h", edge_n, obs_v, exp_v);
        end
        if (!en) begin
          n_cmp++;
          if (mif.period_valid !== 1'b0 || mif.timeout !== 1'b0 || mif.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL enable_low_quiet edge=%0d pv=%b to=%b busy=%b want 0", edge_n,
                     mif.period_valid, mif.timeout, mif.busy);
          end
        end
        if (restored && mif.rise_tick === 1'b1) rt_cnt++;
        if (restored && !first_seen && mif.period_valid === 1'b1) begin
          first_seen = 1'b1;
          n_cmp++;
          if (rt_cnt != 2 || mif.period_out !== 26'd20) begin
            n_bad++;
            $display("FAIL enable_restore_first rises=%0d period=%0d want 2/20", rt_cnt, mif.period_out);
          end
        end
      end
    end
    n_cmp++;
    if (!first_seen) begin
      n_bad++;
      $display("FAIL enable_restore_valid got=none want=one");
    end
  endtask

  task automatic test_reset_mid();
    int rt_cnt = 0;
    int pv_cnt = 0;
    for (int c = 0; c < 15; c++) cycle(1'b1, c < 10);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs_v !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_async got=%h want=0", obs_v);
    end
    mif.slow_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 8; c++) begin
      cycle(1'b1, 1'b1);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL reset_mid edge=%0d got=%h want=%h", edge_n, obs_v, exp_v);
      end
      if (mif.rise_tick === 1'b1) rt_cnt++;
      if (mif.period_valid === 1'b1) pv_cnt++;
    end
    n_cmp++;
    if (rt_cnt != 1 || pv_cnt != 0 || mif.period_out !== 26'd0) begin
      n_bad++;
      $display("FAIL reset_mid_first_rise rises=%0d valids=%0d period=%0d want 1/0/0",
               rt_cnt, pv_cnt, mif.period_out);
    end
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 20; c++) begin
        cycle(1'b1, c >= 10);
        n_cmp++;
        if (obs_v !== exp_v) begin
          n_bad++;
          $display("FAIL reset_mid_after edge=%0d got=%h want=%h", edge_n, obs_v, exp_v);
        end
      end
    end
  endtask

  task automatic test_random();
    int   hi, lo, d0, dlen;
    bit   drop;
    logic en;
    for (int s = 0; s < 40; s++) begin
      hi   = int'($urandom_range(2, 40));
      lo   = int'($urandom_range(2, 40));
      drop = ($urandom_range(0, 7) == 0);
      d0   = int'($urandom_range(0, 30));
      dlen = int'($urandom_range(1, 30));
      for (int c = 0; c < hi + lo; c++) begin
        en = !(drop && c >= d0 && c < d0 + dlen);
        cycle(en, c < hi);
        n_cmp++;
        if (obs_v !== exp_v) begin
          n_bad++;
          $display("FAIL random edge=%0d got=%h want=%h", edge_n, obs_v, exp_v);
        end
        n_cmp++;
        if ((mif.period_valid & mif.timeout) !== 1'b0) begin
          n_bad++;
          $display("FAIL random_exclusive edge=%0d pv=%b to=%b", edge_n, mif.period_valid, mif.timeout);
        end
      end
    end
  endtask

  initial begin
    mif.enable  = 1'b0;
    mif.slow_in = 1'b0;
    rst_n       = 1'b1;
    edge_n      = 0;
    last_rise   = 0;
    model_reset();
    test_reset();
    test_square10();
    test_timeout();
    test_exact64();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
